// File: rtl/key_event_counter_pkg.sv
// Shared types and constants for key_event_counter: FSM encoding, BCD digit
// width and the two-digit count payload.
package key_event_counter_pkg;

    localparam int unsigned STATE_W     = 2;
    localparam int unsigned BCD_DIGIT_W = 4;
    localparam int unsigned BCD_COUNT_W = 2 * BCD_DIGIT_W;

    localparam logic [BCD_DIGIT_W-1:0] BCD_MAX_DIGIT = BCD_DIGIT_W'(9);

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        HELD  = 2'd2
    } key_state_e;

    typedef struct packed {
        logic [BCD_DIGIT_W-1:0] tens;
        logic [BCD_DIGIT_W-1:0] ones;
    } bcd_count_t;

    // Next BCD value; anything at or above 9 returns to 0 so a digit can
    // never leave the BCD range.
    function automatic logic [BCD_DIGIT_W-1:0] bcd_next(input logic [BCD_DIGIT_W-1:0] d);
        if (d >= BCD_MAX_DIGIT) begin
            return '0;
        end
        return d + BCD_DIGIT_W'(1);
    endfunction

endpackage

// File: rtl/key_event_counter_bcd_digit.sv
// Single BCD digit with increment enable, synchronous reset and a carry that
// fires in the cycle the digit wraps 9 -> 0.
module bcd_digit
    import key_event_counter_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inc,
    output logic [BCD_DIGIT_W-1:0] digit,
    output logic                   carry_out
);

    always_ff @(posedge clk) begin
        if (rst) begin
            digit <= '0;
        end else if (inc) begin
            digit <= bcd_next(digit);
        end
    end

    assign carry_out = inc && (digit == BCD_MAX_DIGIT);

endmodule

// File: rtl/key_event_counter.sv
// Key press classifier with two-digit BCD event counter.
// Long-press detection is built only when KEY_EVENT_LONG_PRESS_EN is defined.
module key_event_counter
    import key_event_counter_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   key_in,
    output logic                   press_pulse,
    output logic                   long_pulse,
    output logic [BCD_COUNT_W-1:0] count_bcd
);

    if (HOLD_CYCLES < 2) begin : g_hold_check
        $error("key_event_counter: HOLD_CYCLES must be at least 2");
    end

    key_state_e state_q;
    key_state_e state_d;
    logic       press_d;

`ifdef KEY_EVENT_LONG_PRESS_EN
    localparam int unsigned      CNT_W     = $clog2(HOLD_CYCLES) + 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] hold_cnt_q;
    logic [CNT_W-1:0] hold_cnt_d;
    logic             long_d;

    // State, hold counter and registered pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_cnt_q  <= '0;
            press_pulse <= 1'b0;
            long_pulse  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            press_pulse <= press_d;
            long_pulse  <= long_d;
        end
    end

    // hold_cnt counts high samples seen so far; it stops at HOLD_LAST
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        press_d    = 1'b0;
        long_d     = 1'b0;
        case (state_q)
            IDLE: begin
                hold_cnt_d = '0;
                if (key_in) begin
                    state_d    = PRESS;
                    hold_cnt_d = CNT_W'(1);
                end
            end
            PRESS: begin
                if (!key_in) begin
                    state_d    = IDLE;
                    hold_cnt_d = '0;
                    press_d    = 1'b1;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d = HELD;
                    long_d  = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!key_in) begin
                    state_d    = IDLE;
                    hold_cnt_d = '0;
                end
            end
            default: begin
                state_d    = IDLE;
                hold_cnt_d = '0;
            end
        endcase
    end
`else
    // State and registered press pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            press_pulse <= 1'b0;
        end else begin
            state_q     <= state_d;
            press_pulse <= press_d;
        end
    end

    // Press is reported on the rising edge of the key; release is silent
    always_comb begin
        state_d = state_q;
        press_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_in) begin
                    state_d = PRESS;
                    press_d = 1'b1;
                end
            end
            PRESS: begin
                if (!key_in) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign long_pulse = 1'b0;
`endif

    bcd_count_t count_q;
    logic       count_inc;
    logic       ones_carry;
    logic       tens_carry_unused;

    assign count_inc = press_pulse | long_pulse;

    bcd_digit u_ones (
        .clk       (clk),
        .rst       (rst),
        .inc       (count_inc),
        .digit     (count_q.ones),
        .carry_out (ones_carry)
    );

    bcd_digit u_tens (
        .clk       (clk),
        .rst       (rst),
        .inc       (ones_carry),
        .digit     (count_q.tens),
        .carry_out (tens_carry_unused)
    );

    assign count_bcd = count_q;

endmodule

// File: tb/tb_key_event_counter.sv
// Scoreboard bench for key_event_counter: directed and random key patterns are
// scored against a run-length model of the key behaviour.
module tb_key_event_counter;

    localparam int HOLD = 8;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       key_in = 1'b1;
    logic       press_pulse;
    logic       long_pulse;
    logic [7:0] count_bcd;

    key_event_counter #(.HOLD_CYCLES(HOLD)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_in      (key_in),
        .press_pulse (press_pulse),
        .long_pulse  (long_pulse),
        .count_bcd   (count_bcd)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       p;
        logic       l;
        logic [7:0] c;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Model state: events completed at the previous edge and the decimal count
    bit m_p   = 1'b0;
    bit m_l   = 1'b0;
    int m_cnt = 0;
`ifdef KEY_EVENT_LONG_PRESS_EN
    int m_run = 0;
`else
    bit m_prev = 1'b0;
`endif

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int c);
        return {4'(c / 10), 4'(c % 10)};
    endfunction

    task automatic model_edge(input bit r, input bit k);
        exp_t e;
        if (r) begin
            m_p   = 1'b0;
            m_l   = 1'b0;
            m_cnt = 0;
`ifdef KEY_EVENT_LONG_PRESS_EN
            m_run = 0;
`else
            m_prev = 1'b0;
`endif
        end else begin
            if (m_p || m_l) m_cnt = (m_cnt + 1) % 100;
`ifdef KEY_EVENT_LONG_PRESS_EN
            if (k) begin
                if (m_run <= HOLD) m_run = m_run + 1;
                m_l = (m_run == HOLD);
                m_p = 1'b0;
            end else begin
                m_p   = (m_run >= 1) && (m_run < HOLD);
                m_l   = 1'b0;
                m_run = 0;
            end
`else
            m_p    = k && !m_prev;
            m_l    = 1'b0;
            m_prev = k;
`endif
        end
        e.p = m_p;
        e.l = m_l;
        e.c = to_bcd(m_cnt);
        q.push_back(e);
    endtask

    task automatic step(input bit r, input bit k);
        @(negedge clk);
        rst    = r;
        key_in = k;
        model_edge(r, k);
    endtask

    task automatic press(input int n_high, input int n_low);
        repeat (n_high) step(1'b0, 1'b1);
        repeat (n_low) step(1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && q.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
            q.delete();
        end
    endtask

    // Monitor: outputs are valid every cycle, one expectation per driven edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("press_pulse", {7'b0, press_pulse}, {7'b0, e.p});
                check("long_pulse", {7'b0, long_pulse}, {7'b0, e.l});
                check("count_bcd", count_bcd, e.c);
                check("pulse_exclusive", {7'b0, press_pulse & long_pulse}, 8'h00);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with key high, then a full hold after release of reset
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        drain();
        repeat (HOLD) step(1'b0, 1'b1);
        press(0, 2);
        drain();
        check("reset_then_hold_count", count_bcd, 8'h01);

        // Short press
        step(1'b1, 1'b0);
        press(3, 3);
        drain();
        check("short_count", count_bcd, 8'h01);

        // Threshold boundary: one sample short, then exactly reached and held
        step(1'b1, 1'b0);
        press(HOLD - 1, 3);
        drain();
        check("boundary_short_count", count_bcd, 8'h01);
        press(HOLD + 20, 3);
        drain();
        check("boundary_long_count", count_bcd, 8'h02);

        // BCD wrap through 09->10 and 99->00
        step(1'b1, 1'b0);
        for (int i = 1; i <= 100; i++) begin
            press(2, 2);
            if (i == 9 || i == 10 || i == 99 || i == 100) begin
                drain();
                case (i)
                    9:       check("wrap_09", count_bcd, 8'h09);
                    10:      check("wrap_10", count_bcd, 8'h10);
                    99:      check("wrap_99", count_bcd, 8'h99);
                    default: check("wrap_00", count_bcd, 8'h00);
                endcase
            end
        end

        // Reset in the middle of a press, then a press starting out of reset
        step(1'b1, 1'b0);
        press(2, 2);
        repeat (5) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        press(0, 6);
        drain();
        check("midreset_count", count_bcd, 8'h00);
        step(1'b1, 1'b1);
        press(3, 2);
        drain();
        check("after_reset_press_count", count_bcd, 8'h01);

        // Random key patterns with occasional resets
        step(1'b1, 1'b0);
        repeat (300) begin
            if ($urandom_range(0, 29) == 0) begin
                step(1'b1, 1'($urandom_range(0, 1)));
            end else begin
                press(int'($urandom_range(1, 12)), int'($urandom_range(1, 3)));
            end
        end
        press(0, 3);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/key_event_counter.md
KEY_EVENT_COUNTER -- requirements
Module: key_event_counter

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 8: consecutive high samples of key_in that make a long press; legal range >= 2.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset; synchronous and active-high.
REQ-004 SHALL have port key_in, input, 1 bit: debounced key level from the upstream debouncer; 1 means pressed.
REQ-005 SHALL have port press_pulse, output, 1 bit: one-cycle pulse for a completed short press.
REQ-006 SHALL have port long_pulse, output, 1 bit: one-cycle pulse when a hold reaches HOLD_CYCLES.
REQ-007 SHALL have port count_bcd, output, 8 bits: two-digit BCD event count; [7:4] tens, [3:0] ones.

Function
REQ-008 SHALL sample key_in with no additional synchronisation; key_in is clean, clk-domain data.
REQ-009 SHALL implement a 3-state FSM: IDLE (released), PRESS (held, timing), HELD (long press reported, awaiting release).
REQ-010 IDLE: key_in=1 -> PRESS with hold_cnt<=1; key_in=0 -> remain in IDLE.
REQ-011 PRESS, key_in=0: -> IDLE and press_pulse=1 for exactly the following cycle.
REQ-012 PRESS, key_in=1, hold_cnt==HOLD_CYCLES-1: -> HELD and long_pulse=1 for exactly the following cycle; otherwise hold_cnt increments.
REQ-013 HELD: key_in=1 -> remain in HELD with no further pulses; key_in=0 -> IDLE with no press_pulse.
REQ-014 The Nth consecutive high sample with N=HOLD_CYCLES SHALL produce a long press; N=HOLD_CYCLES-1 followed by a low sample SHALL produce a short press.
REQ-015 hold_cnt width SHALL be clog2(HOLD_CYCLES)+1, and hold_cnt SHALL never wrap.
REQ-016 press_pulse and long_pulse SHALL be registered outputs and SHALL never both be high in the same cycle.
REQ-017 count_bcd SHALL increment in the cycle after any pulse is asserted, with per-digit BCD carry.
REQ-018 count_bcd SHALL roll over 8'h09->8'h10 and 8'h99->8'h00, and SHALL never hold a non-BCD nibble.

Reset
REQ-019 While rst=1 at a clock edge, the block SHALL set FSM=IDLE, hold_cnt=0, press_pulse=0, long_pulse=0 and count_bcd=8'h00.
REQ-020 rst SHALL override all events, including mid-press; a pulse pending at reset SHALL be dropped, not counted.
REQ-021 After rst deasserts with key_in=1, the first high sample SHALL start a new press (IDLE->PRESS).

Configuration
REQ-022 With macro KEY_EVENT_LONG_PRESS_EN defined, the block SHALL implement REQ-009..REQ-014 in full.
REQ-023 Without KEY_EVENT_LONG_PRESS_EN, the block SHALL use a 2-state FSM (IDLE/PRESS) and remove hold_cnt.
REQ-024 Without the macro, press_pulse SHALL fire for one cycle on the IDLE->PRESS transition, and release SHALL produce no pulse.
REQ-025 Without the macro, long_pulse SHALL be tied to 0.
REQ-026 Without the macro, HOLD_CYCLES SHALL be accepted and ignored.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding constants (IDLE=2'd0, PRESS=2'd1, HELD=2'd2) and the BCD digit width constant (4).
REQ-028 One sub-module, bcd_digit, SHALL implement a single 4-bit BCD digit with inc, carry_out and synchronous rst.
REQ-029 count_bcd SHALL be built from two chained bcd_digit instances.

Verification (HOLD_CYCLES=8, macro defined unless stated)
REQ-030 Reset: rst=1 for 2 cycles with key_in=1 -> all outputs 0; after rst drops with key_in=1, 8 high samples -> long_pulse, count_bcd=8'h01.
REQ-031 Short press: key_in high 3 cycles then low -> press_pulse high 1 cycle after the release edge, long_pulse=0, count_bcd=8'h01.
REQ-032 Boundary: 7 high samples then low -> short press; 8 high samples -> long_pulse on the 8th edge, 20 further high cycles give no pulse, release gives no press_pulse.
REQ-033 Wrap: 100 short presses -> count_bcd reads 8'h99 after the 99th press and 8'h00 after the 100th, with 8'h09->8'h10 checked.
REQ-034 Mid-press reset: rst=1 while in PRESS with hold_cnt=5 -> no pulse at any later point, count_bcd=8'h00, FSM=IDLE.
REQ-035 Macro undefined: key_in rises -> press_pulse in the next cycle, long_pulse stays 0 for a 50-cycle hold, release gives no pulse, count_bcd=8'h01.
